multi_clk_div: RTL and testbench

MULTI_CLK_DIV -- requirements
Module: multi_clk_div

---
 rtl/multi_clk_div.sv | 93 +++++++++
 tb/tb_multi_clk_div.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multi_clk_div.sv
// Bank of independent programmable clock dividers. Each channel has a divisor
// that is double-buffered and changes only on a period boundary.

module multi_clk_div_ch #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   input  logic             en,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);
   logic [DIV_W-1:0] active_div, pending_div, cnt;
   logic [DIV_W-1:0] eff, lo;
   logic             run, wrap, hi;

   always_comb begin
      // A divisor of 1 cannot form a 50% clock, so it runs as divide-by-2.
      eff  = (active_div == DIV_W'(1)) ? DIV_W'(2) : active_div;
      lo   = eff - (eff >> 1);
      run  = en && (eff != '0);
      wrap = (cnt == eff - DIV_W'(1));
      hi   = (cnt >= lo);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_div  <= '0;
         pending_div <= '0;
         cnt         <= '0;
         pending     <= 1'b0;
         clk_out     <= 1'b0;
         tick        <= 1'b0;
      end else begin
         if (!run) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
         end else begin
            cnt     <= wrap ? '0 : cnt + DIV_W'(1);
            clk_out <= hi;
            tick    <= hi && !clk_out;
         end
         if (pending && (!run || wrap)) begin
            active_div <= pending_div;
            cnt        <= '0;
            pending    <= 1'b0;
         end
         // A write in the same cycle as an application stays pending.
         if (wr) begin
            pending_div <= wr_div;
            pending     <= 1'b1;
         end
      end
   end
endmodule

module multi_clk_div #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 24,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [DIV_W-1:0]  wr_div,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending
);
   logic [NUM_CH-1:0] wr_hit;

   // Out-of-range channel numbers match no decode and are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr_hit[i] = wr_en && (wr_ch == CH_W'(i));

      multi_clk_div_ch #(.DIV_W(DIV_W)) u_ch (
         .clk     (clk),
         .rst     (rst),
         .wr      (wr_hit[i]),
         .wr_div  (wr_div),
         .en      (ch_en[i]),
         .clk_out (clk_out[i]),
         .tick    (tick[i]),
         .pending (pending[i])
      );
   end
endmodule

// File: tb/tb_multi_clk_div.sv
// Randomized scoreboard bench for multi_clk_div against a phase-count model.

module tb_multi_clk_div;
   localparam int N  = 3;
   localparam int W  = 8;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [CW-1:0] wr_ch;
   logic [W-1:0]  wr_div;
   logic [N-1:0]  ch_en;
   logic [N-1:0]  clk_out, tick, pending;

   multi_clk_div #(.NUM_CH(N), .DIV_W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_div  (wr_div),
      .ch_en   (ch_en),
      .clk_out (clk_out),
      .tick    (tick),
      .pending (pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] c;
      logic [N-1:0] t;
      logic [N-1:0] p;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   errors  = 0;

   // Model: each channel is a phase counter k since its segment started;
   // the waveform is high whenever (k mod eff) lies in the upper part.
   int act[N], pdiv[N], k[N];
   bit pend[N], oclk[N];

   task automatic model_step();
      exp_t e;
      e = '0;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            act[i] = 0; pdiv[i] = 0; k[i] = 0; pend[i] = 0; oclk[i] = 0;
         end else begin
            int  ef, pos, lo;
            bit  run, nc, nt, ap;
            ef  = (act[i] == 1) ? 2 : act[i];
            run = ch_en[i] && (ef != 0);
            pos = run ? (k[i] % ef) : 0;
            lo  = ef - ef / 2;
            nc  = run && (pos >= lo);
            nt  = nc && !oclk[i];
            ap  = pend[i] && (!run || pos == ef - 1);
            k[i] = run ? k[i] + 1 : 0;
            if (ap) begin
               act[i] = pdiv[i]; k[i] = 0; pend[i] = 0;
            end
            if (wr_en && int'(wr_ch) == i) begin
               pdiv[i] = int'(wr_div); pend[i] = 1;
            end
            oclk[i] = nc;
            e.c[i] = nc;
            e.t[i] = nt;
         end
         e.p[i] = pend[i];
      end
      q.push_back(e);
   endtask

   task automatic drive(input logic r, input logic we, input int ch,
                        input int dv, input logic [N-1:0] en);
      @(negedge clk);
      rst    = r;
      wr_en  = we;
      wr_ch  = CW'(ch);
      wr_div = W'(dv);
      ch_en  = en;
      model_step();
   endtask

   task automatic idle(input int n, input logic [N-1:0] en);
      for (int j = 0; j < n; j++) drive(1'b0, 1'b0, 0, 0, en);
   endtask

   // Monitor: one expected vector per clock edge.
   always begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         if (clk_out !== e.c) begin
            errors++;
            $display("FAIL clk_out @%0t got %b want %b", $time, clk_out, e.c);
         end
         if (tick !== e.t) begin
            errors++;
            $display("FAIL tick @%0t got %b want %b", $time, tick, e.t);
         end
         if (pending !== e.p) begin
            errors++;
            $display("FAIL pending @%0t got %b want %b", $time, pending, e.p);
         end
      end
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; ch_en = '0;
      drive(1'b1, 1'b0, 0, 0, '1);
      drive(1'b1, 1'b0, 0, 0, '1);
      idle(3, '1);
      // Basic periods: div 4, 5 and 1.
      drive(1'b0, 1'b1, 0, 4, '1);
      drive(1'b0, 1'b1, 1, 5, '1);
      drive(1'b0, 1'b1, 2, 1, '1);
      idle(20, '1);
      // Retime ch0 from 8 to 4 mid-period, then double write 6 then 10.
      drive(1'b0, 1'b1, 0, 8, '1);
      idle(10, '1);
      drive(1'b0, 1'b1, 0, 4, '1);
      idle(12, '1);
      drive(1'b0, 1'b1, 0, 6, '1);
      drive(1'b0, 1'b1, 0, 10, '1);
      idle(25, '1);
      // Invalid channel, then silence ch1, then reset with ch0 pending.
      drive(1'b0, 1'b1, 3, 2, '1);
      drive(1'b0, 1'b1, 1, 0, '1);
      idle(12, '1);
      drive(1'b0, 1'b1, 0, 3, '1);
      drive(1'b1, 1'b0, 0, 0, '1);
      idle(10, '1);
      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         logic [N-1:0] en;
         int dv;
         for (int b = 0; b < N; b++) en[b] = ($urandom_range(0, 7) != 0);
         dv = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 40)
                                           : $urandom_range(0, 9);
         drive($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 3), dv, en);
      end
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d left want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
